// File: rtl/ddr5_phy_wrdata_crc_ctrl.sv
// rtl/ddr5_phy_wrdata_crc_ctrl.sv - BL16 write-data framing with appended write-CRC cycle
// Optional macro CRC_ERR_INJ_EN adds err_inj_i to corrupt bit 0 of the emitted CRC cycle.
module ddr5_phy_wrdata_crc_ctrl #(
    parameter int pDRAM_SIZE = 4,
    parameter int pBURST_CYC = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      crc_mode_i,
    input  logic [2*pDRAM_SIZE-1:0]   wrdata_i,
    input  logic                      wrdata_valid_i,
    output logic                      wrdata_ready_o,
    output logic                      crc_en_o,
    output logic [2*pDRAM_SIZE-1:0]   crc_data_o,
    input  logic [2*pDRAM_SIZE-1:0]   crc_code_i,
    output logic [2*pDRAM_SIZE-1:0]   dq_o,
    output logic                      dq_valid_o,
    output logic                      dq_crc_o,
    output logic                      burst_err_o,
`ifdef CRC_ERR_INJ_EN
    input  logic                      err_inj_i,
`endif
    output logic                      busy_o
);

    localparam int W  = 2 * pDRAM_SIZE;
    localparam int CW = (pBURST_CYC > 1) ? $clog2(pBURST_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(pBURST_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    dq_q, dq_d;
    logic            dq_valid_q, dq_valid_d;
    logic            dq_crc_q, dq_crc_d;
    logic            err_q, err_d;
    logic            accept;
    logic            mode_eff;
    logic [W-1:0]    inj_mask;

`ifdef CRC_ERR_INJ_EN
    assign inj_mask = {{(W-1){1'b0}}, err_inj_i};
`else
    assign inj_mask = '0;
`endif

    // Ready is forced high while reset is asserted so the reset output state holds immediately.
    assign wrdata_ready_o = !rst_i || (state_q != CRC);
    assign accept         = wrdata_valid_i && wrdata_ready_o;
    assign mode_eff       = (state_q == IDLE) ? crc_mode_i : mode_q;
    assign crc_en_o       = rst_i && accept && mode_eff;
    assign crc_data_o     = wrdata_i;

    assign dq_o        = dq_q;
    assign dq_valid_o  = dq_valid_q;
    assign dq_crc_o    = dq_crc_q;
    assign burst_err_o = err_q;
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_d     = mode_q;
        dq_d       = dq_q;
        dq_valid_d = 1'b0;
        dq_crc_d   = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = crc_mode_i;
                    count_d = CW'(1);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    if (count_q == LAST_CNT) begin
                        count_d = '0;
                        state_d = mode_q ? CRC : IDLE;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    // A gap inside a burst aborts it; the generator is never enabled again for it.
                    err_d   = 1'b1;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            CRC: begin
                dq_d       = crc_code_i ^ inj_mask;
                dq_valid_d = 1'b1;
                dq_crc_d   = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        if (accept) begin
            dq_d       = wrdata_i;
            dq_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mode_q     <= 1'b0;
            dq_q       <= '0;
            dq_valid_q <= 1'b0;
            dq_crc_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            dq_q       <= dq_d;
            dq_valid_q <= dq_valid_d;
            dq_crc_q   <= dq_crc_d;
            err_q      <= err_d;
        end
    end

endmodule
